// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Optional build macro used by the top: FIFO_WR_ARBITER_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    // Per-requester transfer counters stop here instead of wrapping.
    localparam logic [31:0] STAT_SAT = 32'hFFFF_FFFF;

    // Widest request vector the search helper handles.
    localparam int RR_MAX = 16;

    // Cyclic-priority search: first asserted bit strictly after 'last',
    // wrapping at n. Returns 'last' when nothing is requesting.
    function automatic int rr_next(input logic [RR_MAX-1:0] req,
                                   input int last,
                                   input int n);
        int         idx;
        logic [3:0] bit_sel;
        logic       found;
        rr_next = last;
        found   = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx     = (last + k) % n;
            bit_sel = idx[3:0];
            if (k <= n && !found && req[bit_sel]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin winner search plus the registered last-grant pointer.
// The pointer resets to the highest index so index 0 wins first.
module rr_arbiter_core
    import fifo_arb_pkg::*;
#(
    parameter int pN = 4,
    parameter int pW = $clog2(pN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [pN-1:0] req,
    input  logic          load,
    output logic          any_req,
    output logic [pW-1:0] winner,
    output logic [pW-1:0] ptr_q
);

    logic [pW-1:0] ptr_d;
    int            win_int;

    // Next winner searched from ptr_q+1; pointer advances only on load.
    always_comb begin
        win_int = rr_next(RR_MAX'(req), int'(ptr_q), pN);
        winner  = pW'(win_int);
        any_req = |req;
        ptr_d   = load ? winner : ptr_q;
    end

    // Last-grant pointer register.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= pW'(pN - 1);
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one fifo_sync write port. Words are
// tagged {requester, payload}; grants are bounded to pBURST transfers and
// throttled on almost_full so the single in-flight write never hits full.
// Optional build macro: FIFO_WR_ARBITER_STATS_EN adds per-requester
// saturating transfer counters readable through stat_sel/stat_count.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int pREQUESTERS = 4,
    parameter int pDATA_WIDTH = 16,
    parameter int pBURST      = 8,
    parameter int pTAG_WIDTH  = $clog2(pREQUESTERS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             clear_status,
    input  logic [pREQUESTERS-1:0]           req_valid,
    input  logic [pREQUESTERS*pDATA_WIDTH-1:0] req_data,
    output logic [pREQUESTERS-1:0]           req_ready,
    output logic                             fifo_wen,
    output logic [pTAG_WIDTH+pDATA_WIDTH-1:0] fifo_wdata,
    input  logic                             fifo_full,
    input  logic                             fifo_almost_full,
    input  logic                             fifo_overflow,
    output logic [pTAG_WIDTH-1:0]            grant_idx,
    output logic                             busy,
`ifdef FIFO_WR_ARBITER_STATS_EN
    input  logic [pTAG_WIDTH-1:0]            stat_sel,
    output logic [31:0]                      stat_count,
`endif
    output logic                             overflow_seen
);

    localparam int WW = pTAG_WIDTH + pDATA_WIDTH;

    arb_state_e             state_q, state_d;
    logic [7:0]             burst_q, burst_d;
    logic                   wen_q, wen_d;
    logic [WW-1:0]          wdata_q, wdata_d;
    logic                   ovf_q, ovf_d;
    logic                   load;
    logic                   any_req;
    logic                   xfer;
    logic [pTAG_WIDTH-1:0]  winner;
    logic [pDATA_WIDTH-1:0] g_data;

    rr_arbiter_core #(
        .pN (pREQUESTERS),
        .pW (pTAG_WIDTH)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .load    (load),
        .any_req (any_req),
        .winner  (winner),
        .ptr_q   (grant_idx)
    );

    // FSM next state, per-requester ready, transfer detect and write capture.
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        wen_d     = 1'b0;
        wdata_d   = wdata_q;
        load      = 1'b0;
        xfer      = 1'b0;
        req_ready = '0;
        g_data    = req_data[int'(grant_idx)*pDATA_WIDTH +: pDATA_WIDTH];
        case (state_q)
            IDLE: begin
                // One-cycle arbitration bubble; ready stays low here.
                if (any_req) begin
                    load    = 1'b1;
                    state_d = GRANTED;
                    burst_d = '0;
                end
            end
            GRANTED: begin
                req_ready[grant_idx] = enable & ~fifo_full & ~fifo_almost_full;
                xfer = req_valid[grant_idx] & req_ready[grant_idx];
                if (xfer) begin
                    wen_d   = 1'b1;
                    wdata_d = {grant_idx, g_data};
                    burst_d = burst_q + 8'd1;
                end
                // A stall (valid but not ready) keeps the grant.
                if (!req_valid[grant_idx] ||
                    (xfer && burst_q == 8'(pBURST - 1)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Set has priority over clear.
        ovf_d = fifo_overflow | (ovf_q & ~clear_status);
    end

    // State, burst counter, registered write port and sticky status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            burst_q <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fifo_wen      = wen_q;
    assign fifo_wdata    = wdata_q;
    assign busy          = (state_q == GRANTED);
    assign overflow_seen = ovf_q;

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [31:0] stat_q [pREQUESTERS];
    logic [31:0] stat_d [pREQUESTERS];

    // Saturating per-requester transfer counts; clear_status wipes them.
    always_comb begin
        for (int i = 0; i < pREQUESTERS; i++) begin
            stat_d[i] = stat_q[i];
            if (clear_status)
                stat_d[i] = '0;
            else if (xfer && grant_idx == pTAG_WIDTH'(i) && stat_q[i] != STAT_SAT)
                stat_d[i] = stat_q[i] + 32'd1;
        end
        stat_count = (int'(stat_sel) < pREQUESTERS) ? stat_q[stat_sel] : '0;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < pREQUESTERS; i++) begin
            if (reset) stat_q[i] <= '0;
            else       stat_q[i] <= stat_d[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a cycle reference model checks every cycle,
// a vector table covers the single-requester case, and short sequences
// cover bursts, throttling, release, status and mid-operation reset.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int B  = 8;
    localparam int TW = 2;
    localparam int WW = TW + W;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b1;
    logic           clear_status = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_wen;
    logic [WW-1:0]  fifo_wdata;
    logic           fifo_full = 1'b0;
    logic           fifo_almost_full = 1'b0;
    logic           fifo_overflow = 1'b0;
    logic [TW-1:0]  grant_idx;
    logic           busy;
    logic           overflow_seen;
    logic [TW-1:0]  stat_sel = '0;
    logic [31:0]    stat_count;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(
        .pREQUESTERS (N),
        .pDATA_WIDTH (W),
        .pBURST      (B)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .clear_status     (clear_status),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_wen         (fifo_wen),
        .fifo_wdata       (fifo_wdata),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_overflow    (fifo_overflow),
        .grant_idx        (grant_idx),
        .busy             (busy),
`ifdef FIFO_WR_ARBITER_STATS_EN
        .stat_sel         (stat_sel),
        .stat_count       (stat_count),
`endif
        .overflow_seen    (overflow_seen)
    );

`ifndef FIFO_WR_ARBITER_STATS_EN
    assign stat_count = '0;
`endif

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (spec-level) ----------------
    bit            m_busy  = 1'b0;
    int            m_grant = N - 1;
    int            m_cnt   = 0;
    bit            m_wen   = 1'b0;
    logic [WW-1:0] m_wdata = '0;
    bit            m_ovf   = 1'b0;
    logic [31:0]   m_stat [N] = '{default: 32'd0};

    task automatic model_cycle();
        logic [N-1:0] exp_ready;
        bit           xf;
        bit           found;
        int           idx;
        exp_ready = '0;
        if (m_busy && enable && !fifo_full && !fifo_almost_full) exp_ready[m_grant] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant_idx", 64'(grant_idx), 64'(m_grant));
        chk("fifo_wen", 64'(fifo_wen), 64'(m_wen));
        if (m_wen) chk("fifo_wdata", 64'(fifo_wdata), 64'(m_wdata));
        chk("overflow_seen", 64'(overflow_seen), 64'(m_ovf));
`ifdef FIFO_WR_ARBITER_STATS_EN
        chk("stat_count", 64'(stat_count), 64'(m_stat[stat_sel]));
`endif
        xf = m_busy && req_valid[m_grant] && exp_ready[m_grant];
        if (reset) begin
            m_busy = 0; m_grant = N - 1; m_cnt = 0; m_wen = 0; m_wdata = '0; m_ovf = 0;
            for (int i = 0; i < N; i++) m_stat[i] = 32'd0;
        end else begin
            m_wen = xf;
            if (xf) m_wdata = {TW'(m_grant), req_data[m_grant*W +: W]};
            m_ovf = fifo_overflow || (m_ovf && !clear_status);
            for (int i = 0; i < N; i++) begin
                if (clear_status) m_stat[i] = 32'd0;
                else if (xf && i == m_grant && m_stat[i] != 32'hFFFF_FFFF) m_stat[i] = m_stat[i] + 1;
            end
            if (!m_busy) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_grant + k) % N;
                    if (!found && req_valid[idx]) begin
                        found = 1; m_grant = idx; m_busy = 1; m_cnt = 0;
                    end
                end
            end else begin
                if (xf) m_cnt++;
                if (!req_valid[m_grant] || (xf && m_cnt == B)) m_busy = 0;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        model_cycle();
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [N-1:0]  valid;
        logic [W-1:0]  data;
        logic [N-1:0]  ready;
        logic          wen;
        logic [WW-1:0] wdata;
        logic [TW-1:0] grant;
        logic          busy;
    } vec_t;

    vec_t tbl [6];

    task automatic do_reset();
        @(negedge clk);
        reset = 1; req_valid = '0; fifo_almost_full = 0; fifo_full = 0;
        enable = 1; fifo_overflow = 0; clear_status = 0;
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        int n_xfer;
        int n_wen;
        int n_ovf;
        bit exp_w;

        tbl[0] = '{4'b0100, 16'h00A1, 4'b0000, 1'b0, '0,                  2'd3, 1'b0};
        tbl[1] = '{4'b0100, 16'h00A1, 4'b0100, 1'b0, '0,                  2'd2, 1'b1};
        tbl[2] = '{4'b0100, 16'h00A2, 4'b0100, 1'b1, {2'd2, 16'h00A1},    2'd2, 1'b1};
        tbl[3] = '{4'b0100, 16'h00A3, 4'b0100, 1'b1, {2'd2, 16'h00A2},    2'd2, 1'b1};
        tbl[4] = '{4'b0000, 16'h0000, 4'b0100, 1'b1, {2'd2, 16'h00A3},    2'd2, 1'b1};
        tbl[5] = '{4'b0000, 16'h0000, 4'b0000, 1'b0, '0,                  2'd2, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst fifo_wen", 64'(fifo_wen), 64'd0);
        chk("rst fifo_wdata", 64'(fifo_wdata), 64'd0);
        chk("rst grant_idx", 64'(grant_idx), 64'd3);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst overflow_seen", 64'(overflow_seen), 64'd0);

        // Single requester 2, three words
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_valid = tbl[i].valid;
            req_data = '0;
            req_data[2*W +: W] = tbl[i].data;
            #1;
            chk($sformatf("vec%0d ready", i), 64'(req_ready), 64'(tbl[i].ready));
            chk($sformatf("vec%0d wen", i), 64'(fifo_wen), 64'(tbl[i].wen));
            if (tbl[i].wen) chk($sformatf("vec%0d wdata", i), 64'(fifo_wdata), 64'(tbl[i].wdata));
            chk($sformatf("vec%0d grant", i), 64'(grant_idx), 64'(tbl[i].grant));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].busy));
            @(negedge clk);
        end

        // All requesters valid: 8-word bursts in order 0,1,2,3,0 with a bubble
        do_reset();
        for (int t = 0; t < 45; t++) begin
            req_valid = 4'hF;
            req_data = {$urandom, $urandom};
            #1;
            exp_w = (t >= 2) && (t % 9 != 1);
            chk($sformatf("burst t%0d wen", t), 64'(fifo_wen), 64'(exp_w));
            if (exp_w) chk($sformatf("burst t%0d tag", t), 64'(fifo_wdata[WW-1:W]), 64'(((t - 2) / 9) % 4));
            @(negedge clk);
        end

        // almost_full for 5 cycles in the middle of requester 1's burst
        do_reset();
        n_xfer = 0; n_wen = 0;
        for (int t = 0; t < 16; t++) begin
            req_valid = 4'b0010;
            req_data = {$urandom, $urandom};
            fifo_almost_full = (t >= 4 && t <= 8);
            #1;
            if (fifo_almost_full) begin
                chk("afull ready", 64'(req_ready), 64'd0);
                chk("afull busy", 64'(busy), 64'd1);
                chk("afull grant", 64'(grant_idx), 64'd1);
            end
            if (t >= 1 && t <= 13 && req_ready[1]) n_xfer++;
            if (t <= 14 && fifo_wen) n_wen++;
            if (t == 13) chk("afull last busy", 64'(busy), 64'd1);
            if (t == 14) chk("afull released", 64'(busy), 64'd0);
            @(negedge clk);
        end
        fifo_almost_full = 0;
        chk("afull xfers", 64'(n_xfer), 64'd8);
        chk("afull writes", 64'(n_wen), 64'd8);

        // Requester 1 drops after 3 words; requester 2 then gets a full burst
        do_reset();
        n_wen = 0;
        for (int t = 0; t < 16; t++) begin
            req_valid = (t < 4) ? 4'b0110 : 4'b0100;
            req_data = {$urandom, $urandom};
            #1;
            if (fifo_wen && fifo_wdata[WW-1:W] == 2'd1) n_wen++;
            if (t == 4)  chk("drop grant1", 64'(grant_idx), 64'd1);
            if (t == 5)  chk("drop idle", 64'(busy), 64'd0);
            if (t == 6)  chk("drop grant2", 64'(grant_idx), 64'd2);
            if (t == 13) chk("drop r2 busy", 64'(busy), 64'd1);
            if (t == 14) chk("drop r2 done", 64'(busy), 64'd0);
            @(negedge clk);
        end
        chk("drop r1 words", 64'(n_wen), 64'd3);

        // Overflow sticky / clear, then coincident set+clear
        do_reset();
        n_ovf = 0;
        for (int t = 0; t < 17; t++) begin
            req_valid = '0;
            fifo_overflow = (t == 1) || (t == 13);
            clear_status  = (t == 5) || (t == 13) || (t == 15);
            #1;
            if (t <= 12 && overflow_seen) n_ovf++;
            if (t == 2)  chk("ovf set", 64'(overflow_seen), 64'd1);
            if (t == 6)  chk("ovf clr", 64'(overflow_seen), 64'd0);
            if (t == 14) chk("ovf set wins", 64'(overflow_seen), 64'd1);
            if (t == 16) chk("ovf clr2", 64'(overflow_seen), 64'd0);
            @(negedge clk);
        end
        fifo_overflow = 0; clear_status = 0;
        chk("ovf cycles", 64'(n_ovf), 64'd4);

        // Reset on the cycle after a transfer drops the in-flight write
        do_reset();
        req_valid = 4'b0001; req_data = 64'h1234;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        chk("mid rst pending wen", 64'(fifo_wen), 64'd1);
        @(negedge clk);
        reset = 0; req_valid = '0;
        #1;
        chk("mid rst wen", 64'(fifo_wen), 64'd0);
        chk("mid rst grant", 64'(grant_idx), 64'd3);
        chk("mid rst busy", 64'(busy), 64'd0);
        @(negedge clk);

`ifdef FIFO_WR_ARBITER_STATS_EN
        // Transfer counter for requester 0
        do_reset();
        stat_sel = '0; n_xfer = 0;
        for (int t = 0; t < 200 && n_xfer < 20; t++) begin
            req_valid = 4'b0001;
            req_data = {$urandom, $urandom};
            #1;
            if (req_ready[0]) n_xfer++;
            @(negedge clk);
        end
        req_valid = '0;
        chk("stats transfers reached", 64'(n_xfer), 64'd20);
        @(negedge clk);
        #1;
        chk("stats count", 64'(stat_count), 64'd20);
        do_reset();
        #1;
        chk("stats after reset", 64'(stat_count), 64'd0);
`endif

        // Randomized traffic checked by the model
        do_reset();
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) req_valid[i] = ~req_valid[i];
            req_data = {$urandom, $urandom};
            fifo_almost_full = ($urandom_range(7) == 0);
            fifo_full = fifo_almost_full && ($urandom_range(1) == 0);
            enable = ($urandom_range(15) != 0);
            fifo_overflow = ($urandom_range(31) == 0);
            clear_status = ($urandom_range(31) == 0);
            reset = ($urandom_range(299) == 0);
            stat_sel = TW'($urandom_range(N - 1));
            @(negedge clk);
        end
        reset = 0; req_valid = '0; enable = 1;
        fifo_almost_full = 0; fifo_full = 0; fifo_overflow = 0; clear_status = 0;
        repeat (3) @(negedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
